// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press/release/long-press events.
// Optional auto-repeat in the long-held state is enabled by defining BUTTON_EVENT_AUTOREPEAT_EN.
module button_event_gen #(
  parameter int INPUT_ACTIVE_LOW  = 1,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000,
  parameter int CNT_WIDTH         = 26
) (
  input  logic clock,
  input  logic reset_n,
  input  logic buttonIn,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPulse,
  output logic repeatPulse,
  output logic held
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_e;

  localparam logic [CNT_WIDTH-1:0] LONG_TC = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);

  // Reject configurations whose terminal counts are too small or do not fit the counter.
  if (LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      ((LONG_PRESS_CYCLES - 1) >> CNT_WIDTH) != 0 ||
      ((REPEAT_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_params
    $error("button_event_gen: invalid LONG_PRESS_CYCLES/REPEAT_CYCLES/CNT_WIDTH");
  end

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);
`else
  assign repeatPulse = 1'b0;
`endif

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 btn_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      longPulse    <= 1'b0;
      held         <= 1'b0;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
      repeatPulse  <= 1'b0;
`endif
    end else begin
      btn_q        <= (INPUT_ACTIVE_LOW != 0) ? ~buttonIn : buttonIn;
      // Pulses are single-cycle: cleared every edge unless a branch raises one.
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      longPulse    <= 1'b0;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
      repeatPulse  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          held <= 1'b0;
          if (btn_q) begin
            state      <= PRESSED;
            cnt        <= '0;
            pressPulse <= 1'b1;
            held       <= 1'b1;
          end
        end
        PRESSED: begin
          // Release is checked first so it wins over a coincident terminal count.
          if (!btn_q) begin
            state        <= IDLE;
            releasePulse <= 1'b1;
            held         <= 1'b0;
          end else if (cnt == LONG_TC) begin
            state     <= LONG;
            cnt       <= '0;
            longPulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!btn_q) begin
            state        <= IDLE;
            releasePulse <= 1'b1;
            held         <= 1'b0;
          end else begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
            if (cnt == REPEAT_TC) begin
              cnt         <= '0;
              repeatPulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            cnt <= '0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench: an active-high and an active-low instance share reset and see
// the same logical button level, so both must produce identical event streams.
module tb_button_event_gen;

  localparam int LONG_N = 8;
  localparam int REP_N  = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic a_btn = 1'b0;
  logic b_btn = 1'b1;
  logic a_press, a_release, a_long, a_repeat, a_held;
  logic b_press, b_release, b_long, b_repeat, b_held;

  int checks = 0;
  int failures = 0;

  always #10 clock = ~clock;

  button_event_gen #(.INPUT_ACTIVE_LOW(0), .LONG_PRESS_CYCLES(LONG_N),
                     .REPEAT_CYCLES(REP_N), .CNT_WIDTH(4)) dut_hi (
    .clock(clock), .reset_n(reset_n), .buttonIn(a_btn),
    .pressPulse(a_press), .releasePulse(a_release), .longPulse(a_long),
    .repeatPulse(a_repeat), .held(a_held));

  button_event_gen #(.INPUT_ACTIVE_LOW(1), .LONG_PRESS_CYCLES(LONG_N),
                     .REPEAT_CYCLES(REP_N), .CNT_WIDTH(4)) dut_lo (
    .clock(clock), .reset_n(reset_n), .buttonIn(b_btn),
    .pressPulse(b_press), .releasePulse(b_release), .longPulse(b_long),
    .repeatPulse(b_repeat), .held(b_held));

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed{prs,rel,lng,rep,hld}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Both instances are checked against the same expected {press,release,long,repeat,held}.
  task automatic expect_out(input string tag, input logic [4:0] exp);
    check({tag, "/hi"}, {a_press, a_release, a_long, a_repeat, a_held}, exp);
    check({tag, "/lo"}, {b_press, b_release, b_long, b_repeat, b_held}, exp);
  endtask

  task automatic drive(input logic lvl);
    a_btn = lvl;
    b_btn = ~lvl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic rep_at(input int i);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    return (i > LONG_N) && ((i - LONG_N) % REP_N == 0);
`else
    return (i < 0);
`endif
  endfunction

  // Press, stay held for m cycles after the pressPulse cycle (index 0), then release.
  // Release reaches the outputs at index m+2; long at index 8, repeats every 4 after.
  task automatic press_seq(input string name, input int m, input bit repress);
    drive(1'b1);
    tick(); expect_out($sformatf("%s_pre", name), 5'b00000);
    tick(); expect_out($sformatf("%s_press", name), 5'b10001);
    for (int i = 1; i <= m; i++) begin
      tick();
      expect_out($sformatf("%s_hold%0d", name, i), {2'b00, (i == LONG_N), rep_at(i), 1'b1});
    end
    drive(1'b0);
    tick();
    expect_out($sformatf("%s_hold%0d", name, m + 1),
               {2'b00, (m + 1 == LONG_N), rep_at(m + 1), 1'b1});
    if (repress) drive(1'b1);
    tick(); expect_out($sformatf("%s_release", name), 5'b01000);
    if (repress) begin
      tick(); expect_out($sformatf("%s_repress", name), 5'b10001);
      drive(1'b0);
      tick(); expect_out($sformatf("%s_rp_hold", name), 5'b00001);
      tick(); expect_out($sformatf("%s_rp_release", name), 5'b01000);
    end
    tick(); expect_out($sformatf("%s_idle", name), 5'b00000);
  endtask

  initial begin
    // Reset held with the input toggling: nothing may come out.
    for (int i = 0; i < 4; i++) begin
      drive(1'(i % 2));
      tick();
      expect_out($sformatf("rst_toggle%0d", i), 5'b00000);
    end
    drive(1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("post_rst%0d", i), 5'b00000);
    end

    press_seq("short", 1, 1'b0);
    press_seq("rel_at_tc", LONG_N - 2, 1'b0);
    press_seq("long", LONG_N - 1, 1'b0);
    press_seq("repeat", 22, 1'b0);
    press_seq("repress", 2, 1'b1);

    // Reset in the middle of a held press: outputs clear at once, no release event.
    drive(1'b1);
    tick(); expect_out("r5_pre", 5'b00000);
    tick(); expect_out("r5_press", 5'b10001);
    for (int i = 1; i <= 5; i++) begin
      tick(); expect_out($sformatf("r5_hold%0d", i), 5'b00001);
    end
    reset_n = 1'b0;
    #1 expect_out("r5_async_clear", 5'b00000);
    tick(); expect_out("r5_in_reset", 5'b00000);
    reset_n = 1'b1;
    tick(); expect_out("r5_e0", 5'b00000);
    tick(); expect_out("r5_press_after_rst", 5'b10001);
    drive(1'b0);
    tick(); expect_out("r5_hold", 5'b00001);
    tick(); expect_out("r5_release", 5'b01000);
    tick(); expect_out("r5_idle", 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
